pow2_sequencer: RTL and testbench

- Generates powers of two. It is the producer side of the team's power-of-two detector.
- Accepts an exponent over a valid/ready handshake, then walks a single 1 from bit 0 up to bit exp, one position per clock.
- Holds the final one-hot word 2^exp and pulses done.
- Feeds one-hot select/enable buses; its output can be checked directly by the existing detector.

---
 rtl/pow2_sequencer_if.sv | 38 +++
 rtl/pow2_sequencer.sv | 123 ++++++++++++
 tb/tb_pow2_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pow2_sequencer_if.sv
// Request/result bundle for pow2_sequencer.
//   start_valid / start_ready / exp : exponent request handshake
//   out_val                         : current word, zero or one-hot
//   busy / done                     : in-progress flag, one-cycle completion pulse
//   err                             : out-of-range pulse (only when POW2_ERR_EN is defined)
// master: requester side.  slave: the sequencer.
interface pow2_sequencer_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned EXP_W = 2
);
  logic             start_valid;
  logic             start_ready;
  logic [EXP_W-1:0] exp;
  logic [WIDTH-1:0] out_val;
  logic             busy;
  logic             done;
`ifdef POW2_ERR_EN
  logic             err;

  modport master (
    output start_valid, exp,
    input  start_ready, out_val, busy, done, err
  );
  modport slave (
    input  start_valid, exp,
    output start_ready, out_val, busy, done, err
  );
`else
  modport master (
    output start_valid, exp,
    input  start_ready, out_val, busy, done
  );
  modport slave (
    input  start_valid, exp,
    output start_ready, out_val, busy, done
  );
`endif
endinterface

// File: rtl/pow2_sequencer.sv
// Power-of-two sequencer: accepts an exponent over a valid/ready handshake, then walks a single
// 1 from bit 0 up to bit exp, one position per clock, holds 2^exp and pulses done.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : pow2_sequencer_if.slave (start_valid/start_ready/exp in, out_val/busy/done out)
// Optional macro POW2_ERR_EN: adds bus.err; an out-of-range exponent is accepted, leaves out_val
// alone and pulses err instead of running. Without it the exponent saturates to WIDTH-1.
module pow2_sequencer #(
  parameter int unsigned WIDTH = 4,  // one-hot word width, 2..32
  parameter int unsigned EXP_W = 2   // exponent width, 2**EXP_W >= WIDTH
) (
  input logic             clk,
  input logic             rst,
  pow2_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [EXP_W-1:0] target_q, target_d;
  logic [EXP_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
`ifdef POW2_ERR_EN
  logic             err_q, err_d;
`endif

  logic             accept;
  logic             out_of_range;
  logic [EXP_W-1:0] capture;

  assign accept       = bus.start_valid && bus.start_ready;
  assign out_of_range = 32'(bus.exp) >= WIDTH;

`ifdef POW2_ERR_EN
  assign capture = bus.exp;
`else
  // Clamp so the walking 1 can never pass the MSB.
  assign capture = out_of_range ? EXP_W'(WIDTH - 1) : bus.exp;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    count_d  = count_q;
    out_d    = out_q;
    done_d   = 1'b0;
`ifdef POW2_ERR_EN
    err_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef POW2_ERR_EN
          if (out_of_range) begin
            err_d = 1'b1;
          end else begin
`else
          begin
`endif
            target_d = capture;
            count_d  = '0;
            out_d    = WIDTH'(1);
            if (capture == '0) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              state_d = StShift;
            end
          end
        end
      end
      StShift: begin
        out_d   = out_q << 1;
        count_d = count_q + 1'b1;
        // count < target always holds here, so count+1 cannot wrap.
        if (count_q + 1'b1 == target_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      target_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
`ifdef POW2_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      count_q  <= count_d;
      out_q    <= out_d;
      done_q   <= done_d;
`ifdef POW2_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  // Ready is withheld while reset is applied so no request slips in during it.
  assign bus.start_ready = (state_q == StIdle) && !rst;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
  assign bus.out_val     = out_q;
`ifdef POW2_ERR_EN
  assign bus.err         = err_q;
`endif

endmodule

// File: tb/tb_pow2_sequencer.sv
module tb_pow2_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  pow2_sequencer_if #(.WIDTH(4), .EXP_W(2)) a_if ();
  pow2_sequencer_if #(.WIDTH(3), .EXP_W(2)) b_if ();

  pow2_sequencer #(.WIDTH(4), .EXP_W(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  pow2_sequencer #(.WIDTH(3), .EXP_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-or-one-hot invariant on both instances every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      assert ($onehot0(a_if.out_val)) else begin
        errors++;
        $error("FAIL onehot_a: observed=%0h expected=zero_or_onehot", a_if.out_val);
      end
      checks++;
      assert ($onehot0(b_if.out_val)) else begin
        errors++;
        $error("FAIL onehot_b: observed=%0h expected=zero_or_onehot", b_if.out_val);
      end
    end
  end

  initial begin
    rst = 1'b0;
    a_if.start_valid = 1'b0;
    a_if.exp = '0;
    b_if.start_valid = 1'b0;
    b_if.exp = '0;

    // Asynchronous reset between clock edges.
    #2 rst = 1'b1;
    #1;
    chk("rst_out", a_if.out_val, 4'b0000);
    chk("rst_done", a_if.done, 1'b0);
    chk("rst_busy", a_if.busy, 1'b0);
    chk("rst_out_b", b_if.out_val, 3'b000);
    #9 rst = 1'b0;
    #1;
    chk("rel_ready", a_if.start_ready, 1'b1);
    chk_on = 1'b1;

    // exp = 0
    a_if.start_valid = 1'b1;
    a_if.exp = 2'd0;
    step();
    chk("e0_out", a_if.out_val, 4'b0001);
    chk("e0_done", a_if.done, 1'b1);
    chk("e0_busy", a_if.busy, 1'b1);
    chk("e0_ready", a_if.start_ready, 1'b0);
    a_if.start_valid = 1'b0;
    step();
    chk("e0_done_off", a_if.done, 1'b0);
    chk("e0_idle_busy", a_if.busy, 1'b0);
    chk("e0_idle_ready", a_if.start_ready, 1'b1);
    chk("e0_hold", a_if.out_val, 4'b0001);

    // exp = 3
    a_if.start_valid = 1'b1;
    a_if.exp = 2'd3;
    step();
    chk("e3_out0", a_if.out_val, 4'b0001);
    chk("e3_busy0", a_if.busy, 1'b1);
    chk("e3_done0", a_if.done, 1'b0);
    a_if.start_valid = 1'b0;
    step();
    chk("e3_out1", a_if.out_val, 4'b0010);
    chk("e3_done1", a_if.done, 1'b0);
    step();
    chk("e3_out2", a_if.out_val, 4'b0100);
    chk("e3_done2", a_if.done, 1'b0);
    chk("e3_busy2", a_if.busy, 1'b1);
    step();
    chk("e3_out3", a_if.out_val, 4'b1000);
    chk("e3_done3", a_if.done, 1'b1);
    chk("e3_busy3", a_if.busy, 1'b1);
    step();
    chk("e3_done_off", a_if.done, 1'b0);
    chk("e3_busy_off", a_if.busy, 1'b0);
    chk("e3_hold", a_if.out_val, 4'b1000);
    chk("e3_ready", a_if.start_ready, 1'b1);

    // Request held while busy: exp=2 runs, then the held exp=1 is taken.
    a_if.start_valid = 1'b1;
    a_if.exp = 2'd2;
    step();
    chk("bz_out0", a_if.out_val, 4'b0001);
    a_if.exp = 2'd1;
    chk("bz_ready0", a_if.start_ready, 1'b0);
    step();
    chk("bz_out1", a_if.out_val, 4'b0010);
    chk("bz_done1", a_if.done, 1'b0);
    step();
    chk("bz_out2", a_if.out_val, 4'b0100);
    chk("bz_done2", a_if.done, 1'b1);
    chk("bz_ready2", a_if.start_ready, 1'b0);
    step();
    chk("bz_idle_out", a_if.out_val, 4'b0100);
    chk("bz_idle_done", a_if.done, 1'b0);
    chk("bz_idle_ready", a_if.start_ready, 1'b1);
    step();
    chk("bz2_out0", a_if.out_val, 4'b0001);
    chk("bz2_busy0", a_if.busy, 1'b1);
    a_if.start_valid = 1'b0;
    step();
    chk("bz2_out1", a_if.out_val, 4'b0010);
    chk("bz2_done1", a_if.done, 1'b1);
    step();
    chk("bz2_done_off", a_if.done, 1'b0);
    chk("bz2_hold", a_if.out_val, 4'b0010);

    // Reset mid-operation.
    a_if.start_valid = 1'b1;
    a_if.exp = 2'd3;
    step();
    a_if.start_valid = 1'b0;
    step();
    chk("mr_out1", a_if.out_val, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("mr_out", a_if.out_val, 4'b0000);
    chk("mr_busy", a_if.busy, 1'b0);
    chk("mr_done", a_if.done, 1'b0);
    #2 rst = 1'b0;
    step();
    chk("mr_done_a", a_if.done, 1'b0);
    chk("mr_busy_a", a_if.busy, 1'b0);
    chk("mr_ready_a", a_if.start_ready, 1'b1);
    step();
    chk("mr_done_b", a_if.done, 1'b0);
    chk("mr_out_b", a_if.out_val, 4'b0000);

    // Out-of-range on WIDTH=3: exp=3.
    b_if.start_valid = 1'b1;
    b_if.exp = 2'd3;
    step();
    b_if.start_valid = 1'b0;
`ifdef POW2_ERR_EN
    chk("oor_err", b_if.err, 1'b1);
    chk("oor_out0", b_if.out_val, 3'b000);
    chk("oor_busy0", b_if.busy, 1'b0);
    chk("oor_done0", b_if.done, 1'b0);
    step();
    chk("oor_err_off", b_if.err, 1'b0);
    chk("oor_out1", b_if.out_val, 3'b000);
    chk("oor_done1", b_if.done, 1'b0);
    chk("oor_ready", b_if.start_ready, 1'b1);
`else
    chk("oor_out0", b_if.out_val, 3'b001);
    chk("oor_busy0", b_if.busy, 1'b1);
    chk("oor_done0", b_if.done, 1'b0);
    step();
    chk("oor_out1", b_if.out_val, 3'b010);
    chk("oor_done1", b_if.done, 1'b0);
    step();
    chk("oor_out2", b_if.out_val, 3'b100);
    chk("oor_done2", b_if.done, 1'b1);
    step();
    chk("oor_done_off", b_if.done, 1'b0);
    chk("oor_hold", b_if.out_val, 3'b100);
    chk("oor_ready", b_if.start_ready, 1'b1);
`endif

    step();
    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
